// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one request in flight to
// instruction memory, and holds the fetched instruction for the controller.
module fetch_unit #(
   parameter int unsigned        XLEN      = 32,
   parameter logic [XLEN-1:0]    RESET_PC  = '0,
   parameter logic [31:0]        NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            PCSrc,
   input  logic [XLEN-1:0] PCTarget,
   input  logic            stall,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     Instr,
   output logic [6:0]      op,
   output logic [2:0]      funct3,
   output logic            funct7b5,
   output logic            instr_valid,
   output logic [XLEN-1:0] PC,
   output logic [XLEN-1:0] PCPlus4,
   output logic            misaligned,
   output logic [31:0]     icount
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_ISSUE} state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     instr_q, instr_d;
   logic [31:0]     icount_q, icount_d;
   logic            instr_valid_q, instr_valid_d;
   logic            imem_req_q, imem_req_d;
   logic            misaligned_q, misaligned_d;
   logic [XLEN-1:0] pc_plus4;
   logic            retire;

   assign pc_plus4 = pc_q + XLEN'(4);
   assign retire   = (state_q == S_ISSUE) && !stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: state_d = S_WAIT;
         S_WAIT:  if (imem_rvalid) state_d = S_ISSUE;
         S_ISSUE: if (!stall) state_d = S_FETCH;
      endcase
   end

   // Registered outputs are computed from the next state so they line up with it.
   always_comb begin
      pc_d          = pc_q;
      instr_d       = instr_q;
      icount_d      = icount_q;
      misaligned_d  = 1'b0;
      imem_req_d    = (state_d == S_FETCH);
      instr_valid_d = (state_d == S_ISSUE);
      if ((state_q == S_WAIT) && imem_rvalid) begin
         instr_d = imem_rdata;
      end
      if (retire) begin
         icount_d     = icount_q + 32'd1;
         pc_d         = PCSrc ? {PCTarget[XLEN-1:2], 2'b00} : pc_plus4;
         instr_d      = NOP_INSTR;
         misaligned_d = PCSrc && (PCTarget[1:0] != 2'b00);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         instr_q       <= NOP_INSTR;
         icount_q      <= '0;
         instr_valid_q <= 1'b0;
         imem_req_q    <= 1'b0;
         misaligned_q  <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         icount_q      <= icount_d;
         instr_valid_q <= instr_valid_d;
         imem_req_q    <= imem_req_d;
         misaligned_q  <= misaligned_d;
      end
   end

   assign imem_req    = imem_req_q;
   assign imem_addr   = pc_q;
   assign PC          = pc_q;
   assign PCPlus4     = pc_plus4;
   assign Instr       = instr_q;
   assign op          = instr_q[6:0];
   assign funct3      = instr_q[14:12];
   assign funct7b5    = instr_q[30];
   assign instr_valid = instr_valid_q;
   assign misaligned  = misaligned_q;
   assign icount      = icount_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a PC/icount model pushes expected fetches and
// issues; a monitor pops and compares them as the DUT presents requests/instructions.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] addr;
      logic        mis;
   } fetch_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] icnt;
   } issue_t;

   logic        clk;
   logic        reset;
   logic        PCSrc;
   logic [31:0] PCTarget;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] Instr;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic        instr_valid;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic        misaligned;
   logic [31:0] icount;

   logic        resp_rv;
   logic [31:0] resp_data;
   logic        stale_rv;
   int          next_lat;
   logic [31:0] seed;

   fetch_t      fetch_q[$];
   issue_t      issue_q[$];
   logic [31:0] exp_pc;
   logic [31:0] exp_icount;

   int n_pass;
   int n_total;

   assign imem_rvalid = resp_rv | stale_rv;
   assign imem_rdata  = stale_rv ? 32'hDEAD_BEEF : resp_data;

   fetch_unit #(
      .XLEN(32), .RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)
   ) dut (
      .clk(clk), .reset(reset), .PCSrc(PCSrc), .PCTarget(PCTarget), .stall(stall),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .Instr(Instr), .op(op), .funct3(funct3),
      .funct7b5(funct7b5), .instr_valid(instr_valid), .PC(PC), .PCPlus4(PCPlus4),
      .misaligned(misaligned), .icount(icount)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      if (a == 32'h0) return 32'h0050_0093;
      w = (a ^ seed) * 32'h9E37_79B1;
      return w ^ (w >> 13);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic finish_run();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   endtask

   task automatic push_issue();
      issue_q.push_back('{pc: exp_pc, instr: mem_word(exp_pc), icnt: exp_icount});
   endtask

   task automatic junk();
      stall    = 1'($urandom);
      PCSrc    = 1'($urandom);
      PCTarget = $urandom;
   endtask

   // Memory: answers each request after next_lat cycles, forgets everything on reset.
   initial begin
      int          cnt;
      bit          pend;
      logic [31:0] addr;
      resp_rv = 1'b0; resp_data = '0; pend = 0; cnt = 0; addr = '0;
      forever begin
         @(negedge clk);
         resp_rv = 1'b0;
         if (reset) begin
            pend = 0;
         end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
               resp_rv   = 1'b1;
               resp_data = mem_word(addr);
               pend      = 0;
            end
         end else if (imem_req) begin
            pend = 1; cnt = next_lat; addr = imem_addr;
         end
      end
   end

   // Monitor / scoreboard
   initial begin
      int     cyc, fetch_cyc, fetch_lat;
      bit     prev_v;
      fetch_t f;
      issue_t cur;
      cyc = 0; fetch_cyc = 0; fetch_lat = 0; prev_v = 0; cur = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            prev_v = 0;
         end else begin
            if (imem_req) begin
               chk("req_while_valid", 32'(instr_valid), 32'd0);
               if (fetch_q.size() == 0) begin
                  n_total++;
                  $display("FAIL unexpected_req: imem_addr %h with no fetch pending", imem_addr);
               end else begin
                  f = fetch_q.pop_front();
                  chk("imem_addr", imem_addr, f.addr);
                  chk("fetch_pc", PC, f.addr);
                  chk("misaligned_pulse", 32'(misaligned), 32'(f.mis));
                  fetch_cyc = cyc;
                  fetch_lat = next_lat;
               end
            end else begin
               chk("misaligned_low", 32'(misaligned), 32'd0);
            end
            if (instr_valid) begin
               if (!prev_v) begin
                  if (issue_q.size() == 0) begin
                     n_total++;
                     $display("FAIL unexpected_issue: PC %h Instr %h", PC, Instr);
                  end else begin
                     cur = issue_q.pop_front();
                     chk("issue_latency", 32'(cyc - fetch_cyc), 32'(1 + fetch_lat));
                  end
               end
               chk("issue_pc", PC, cur.pc);
               chk("issue_instr", Instr, cur.instr);
               chk("op", 32'(op), 32'(cur.instr[6:0]));
               chk("funct3", 32'(funct3), 32'(cur.instr[14:12]));
               chk("funct7b5", 32'(funct7b5), 32'(cur.instr[30]));
               chk("icount", icount, cur.icnt);
               chk("pcplus4", PCPlus4, cur.pc + 32'd4);
            end else begin
               chk("instr_nop", Instr, NOP_INSTR);
            end
            prev_v = instr_valid;
         end
      end
   end

   // One instruction: wait for ISSUE, stall nstall cycles, then retire with src/tgt.
   task automatic do_instr(input int nstall, input bit src, input logic [31:0] tgt,
                           input int lat, input bit force_wrap);
      int t;
      t = 0;
      @(negedge clk);
      while (!instr_valid) begin
         if (t == 60) begin
            n_total++;
            $display("FAIL issue_timeout: no instr_valid within 60 cycles, PC %h", PC);
            finish_run();
         end
         junk();
         t++;
         @(negedge clk);
      end
      for (int i = 0; i < nstall; i++) begin
         stall    = 1'b1;
         PCSrc    = 1'($urandom);
         PCTarget = $urandom;
         @(negedge clk);
      end
      stall    = 1'b0;
      PCSrc    = src;
      PCTarget = tgt;
      next_lat = lat;
      @(posedge clk);
      exp_icount = exp_icount + 32'd1;
      exp_pc     = src ? (tgt & 32'hFFFF_FFFC) : exp_pc + 32'd4;
      fetch_q.push_back('{addr: exp_pc, mis: src && (tgt[1:0] != 2'b00)});
      @(negedge clk);
      junk();
      if (force_wrap) begin
         force dut.icount_q = 32'hFFFF_FFFF;
         exp_icount = 32'hFFFF_FFFF;
         #1 release dut.icount_q;
      end
      push_issue();
   endtask

   // Reset while WAIT is pending; then let a stale response hit IDLE and FETCH.
   task automatic reset_mid_wait();
      @(negedge clk);
      #1 reset = 1'b1;
      fetch_q.delete();
      issue_q.delete();
      exp_pc     = RESET_PC;
      exp_icount = '0;
      #1;
      chk("rst_pc", PC, RESET_PC);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_icount", icount, 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_instr", Instr, NOP_INSTR);
      @(negedge clk);
      next_lat = 1;
      fetch_q.push_back('{addr: RESET_PC, mis: 1'b0});
      push_issue();
      #1 reset = 1'b0;
      stale_rv = 1'b1;
      @(negedge clk);
      @(negedge clk);
      stale_rv = 1'b0;
   endtask

   initial begin
      int          ns, l;
      bit          s;
      logic [31:0] tg;
      n_pass = 0; n_total = 0;
      reset = 1'b0; stall = 1'b0; PCSrc = 1'b0; PCTarget = '0;
      stale_rv = 1'b0; next_lat = 1;
      seed = $urandom;
      exp_pc = RESET_PC; exp_icount = '0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("init_pc", PC, RESET_PC);
      chk("init_valid", 32'(instr_valid), 32'd0);
      chk("init_req", 32'(imem_req), 32'd0);
      chk("init_mis", 32'(misaligned), 32'd0);
      chk("init_icount", icount, 32'd0);
      chk("init_instr", Instr, NOP_INSTR);
      fetch_q.push_back('{addr: RESET_PC, mis: 1'b0});
      push_issue();
      #1 reset = 1'b0;
      @(negedge clk);
      chk("idle_one_cycle", 32'(imem_req), 32'd1);

      for (int i = 0; i < 4; i++) do_instr(0, 1'b0, 32'h0, 1, 1'b0);
      do_instr(0, 1'b1, 32'h0000_0040, 1, 1'b0);
      do_instr(5, 1'b0, 32'h0, 1, 1'b0);
      do_instr(0, 1'b1, 32'h0000_0042, 1, 1'b0);
      do_instr(0, 1'b1, 32'hFFFF_FFFC, 4, 1'b0);
      do_instr(0, 1'b0, 32'h0, 1, 1'b1);
      do_instr(1, 1'b0, 32'h0, 4, 1'b0);
      do_instr(2, 1'b0, 32'h0, 4, 1'b0);
      reset_mid_wait();

      for (int k = 0; k < 200; k++) begin
         ns = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         s  = ($urandom_range(0, 2) == 0);
         tg = $urandom;
         if ($urandom_range(0, 1) == 1) tg[1:0] = 2'b00;
         l  = int'($urandom_range(1, 4));
         do_instr(ns, s, tg, l, 1'b0);
      end

      stall = 1'b1;
      for (int t = 0; t < 60 && !instr_valid; t++) @(negedge clk);
      @(negedge clk);
      chk("final_valid", 32'(instr_valid), 32'd1);
      chk("fetch_q_empty", 32'(fetch_q.size()), 32'd0);
      chk("issue_q_empty", 32'(issue_q.size()), 32'd0);
      finish_run();
   end

endmodule
